mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the processor's single unified memory port between two requesters:
//  port 0 = multicycle ARM core (Adr/WriteData/ReadData/MemWrite side),
//  port 1 = program loader / debug master.
//  Serialises accesses, inserts a fixed number of memory wait states, and
//  returns read data with a one-cycle ack.
//  Drives a stall to the core while its access is pending.
// PARAMETERS
//  ADDR_W       32  address width, both ports and memory
//  DATA_W       32  data width, both ports and memory
//  WAIT_CYCLES  0   extra memory cycles before read data is valid / write commits (0..15)
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  reset        in   1       synchronous, active-high
//  cpu_req      in   1       core access request; level, held until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read; stable while cpu_req
//  cpu_adr      in   ADDR_W  core address; stable while cpu_req
//  cpu_wdata    in   DATA_W  core write data; stable while cpu_req
//  cpu_rdata    out  DATA_W  read data; valid in cpu_ack cycle
//  cpu_ack      out  1       one-cycle completion pulse
//  cpu_stall    out  1       cpu_req & ~cpu_ack (combinational)
//  ld_req       in   1       loader request; level, held until ld_ack
//  ld_we        in   1       loader write enable; stable while ld_req
//  ld_adr       in   ADDR_W  loader address
//  ld_wdata     in   DATA_W  loader write data
//  ld_rdata     out  DATA_W  loader read data; valid in ld_ack cycle
//  ld_ack       out  1       one-cycle completion pulse
//  ld_hold      in   1       1 = core requests never granted (program load)
//  mem_adr      out  ADDR_W  memory address (registered)
//  mem_wdata    out  DATA_W  memory write data (registered)
//  mem_we       out  1       memory write strobe, one cycle per write
//  mem_rdata    in   DATA_W  memory read data, valid WAIT_CYCLES cycles after mem_adr
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, last_gnt=LD (core wins first tie), cnt=0.
//  - IDLE: req sampled only here. Eligible = {cpu_req & ~ld_hold, ld_req}.
//    One eligible: grant it. Both: grant port != last_gnt.
//    On grant: latch adr/we/wdata into mem_* regs, owner<=port, cnt<=WAIT_CYCLES,
//    go ACCESS. None: stay; mem_* hold last values, mem_we=0.
//  - ACCESS: cnt!=0 -> cnt--. cnt==0 -> mem_we = latched we (single pulse),
//    rdata_q<=mem_rdata, go RESP. mem_adr/mem_wdata stable throughout ACCESS.
//  - RESP: ack[owner]=1 for exactly one cycle; rdata[owner]=rdata_q
//    (writes return rdata_q as don't-care); last_gnt<=owner; go IDLE.
//  - Latency: req high in IDLE cycle t -> ack in cycle t+WAIT_CYCLES+2.
//    Throughput: one access per WAIT_CYCLES+3 cycles.
//  - Requester drops req the cycle after ack; req still high in next IDLE
//    = new transaction (back-to-back legal, subject to round robin).
//  - Never more than one ack per cycle; non-owner ack and rdata held 0.
//  - ld_hold rising mid-core-transaction: current core access completes;
//    hold gates only the next grant.
//  - req dropped by a requester before ack: protocol violation; arbiter
//    still completes and acks (incl. write).
//  - Reset mid-transaction: abort immediately, no ack, no mem_we pulse
//    after reset cycle, last_gnt returns to LD.
//  - cnt width 4 bits; WAIT_CYCLES>15 is illegal (elaboration check).
// STRUCTURE
//  - mem_arb_defs.vh: state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
//    port ids PORT_CPU=1'b0, PORT_LD=1'b1.
//  - Sub-module mem_arb_rr: 2-way round-robin picker
//    (req[1:0], last_gnt -> gnt_valid, gnt_id), purely combinational.
//  - Top: FSM, wait counter, address/data/we latch, rdata_q, ack/rdata demux.
// TESTING
//  1. WAIT=0, cpu read 0x100 (mem holds 0xDEADBEEF) at t -> cpu_ack at t+2,
//     cpu_rdata=0xDEADBEEF, cpu_stall high t..t+1.
//  2. WAIT=3, ld write 0x20<-0x12345678 -> exactly one mem_we pulse at t+4,
//     ld_ack at t+5, mem_adr=0x20 stable t+1..t+4.
//  3. Both req in same IDLE after reset -> cpu granted first, ld next;
//     repeat with both held -> strict alternation cpu, ld, cpu, ld.
//  4. ld_hold=1, cpu_req and ld_req both high -> only ld acks, cpu_stall
//     stays 1; drop hold -> cpu acked in the following slot.
//  5. reset asserted in ACCESS of a write with WAIT=2 -> no mem_we, no ack,
//     outputs 0 next cycle; fresh cpu read then completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port unified memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the port that was not served last.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick the winning port from the eligible request vector.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    case (req)
      2'b01:   gnt_id = PORT_CPU;
      2'b10:   gnt_id = PORT_LD;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single unified memory port between the multicycle core (port 0)
// and the program loader / debug master (port 1). One access in flight at a
// time: IDLE grant -> ACCESS (wait states) -> RESP (one-cycle ack).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  input  logic              ld_hold,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
      $error("mem_arbiter: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              owner_r;
  logic              we_r;
  logic              last_gnt_r;

  logic [1:0]        elig_s;
  logic              gnt_valid_s;
  logic              gnt_id_s;
  logic [ADDR_W-1:0] sel_adr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;

  // The loader hold only masks the core at grant time, never an access in flight.
  assign elig_s    = {ld_req, cpu_req & ~ld_hold};
  assign cpu_stall = cpu_req & ~cpu_ack;

  mem_arb_rr u_rr (
    .req       (elig_s),
    .last_gnt  (last_gnt_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Route the winning port's command towards the memory-side latches.
  always_comb begin
    sel_adr_s   = cpu_adr;
    sel_wdata_s = cpu_wdata;
    sel_we_s    = cpu_we;
    if (gnt_id_s == PORT_LD) begin
      sel_adr_s   = ld_adr;
      sel_wdata_s = ld_wdata;
      sel_we_s    = ld_we;
    end else begin
      sel_adr_s   = cpu_adr;
      sel_wdata_s = cpu_wdata;
      sel_we_s    = cpu_we;
    end
  end

  // Arbitration FSM, wait counter, command latch and registered ack/rdata demux.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      owner_r    <= PORT_CPU;
      we_r       <= 1'b0;
      last_gnt_r <= PORT_LD;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      mem_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            owner_r   <= gnt_id_s;
            we_r      <= sel_we_s;
            mem_adr   <= sel_adr_s;
            mem_wdata <= sel_wdata_s;
            cnt_r     <= WAIT_INIT;
            // The strobe lands in the last ACCESS cycle, which is the first one when there are no wait states.
            mem_we    <= sel_we_s & (WAIT_INIT == 4'd0);
            state_r   <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r  <= cnt_r - 4'd1;
            mem_we <= we_r & (cnt_r == 4'd1);
          end else begin
            cpu_ack <= (owner_r == PORT_CPU);
            ld_ack  <= (owner_r == PORT_LD);
            if (owner_r == PORT_LD) begin
              ld_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
            state_r <= RESP;
          end
        end
        RESP: begin
          last_gnt_r <= owner_r;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
